mnist_input_streamer: RTL and testbench
=======================================

MNIST_INPUT_STREAMER -- requirements
Module: mnist_input_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the network input sample.
REQ-002 SHALL have parameter PIXEL_NUM, default 784, pixels per image.
REQ-003 SHALL have parameter PIX_WIDTH, default 8, width of a raw pixel.
REQ-004 SHALL have parameter PIX_SHIFT, default 4, left shift that places a raw pixel in the fixed-point sample.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port pix_in  input  PIX_WIDTH  raw pixel.
REQ-008 SHALL have port pix_valid  input  1  pix_in valid.
REQ-009 SHALL have port pix_sof  input  1  marks the first pixel of an image.
REQ-010 SHALL have port pix_ready  output  1  pixel accepted when pix_valid and pix_ready are both high.
REQ-011 SHALL have port net_done  input  1  one-cycle pulse; the network has produced its result.
REQ-012 SHALL have port my_input  output  DATA_WIDTH  sample to the network.
REQ-013 SHALL have port input_valid  output  1  my_input valid.
REQ-014 SHALL have port busy  output  1  an image is streaming or awaiting its result.
REQ-015 SHALL have port img_cnt  output  16  images fully streamed, wraps at 65535 to 0.

Function
REQ-016 SHALL store accepted pixels in a PIXEL_NUM-deep buffer at write address wr_cnt, with wr_cnt incremented per accept.
REQ-017 SHALL write a pixel accepted with pix_sof=1 to address 0 and set wr_cnt to 1, discarding any partial image.
REQ-018 SHALL mark the buffer full when the accept at wr_cnt=PIXEL_NUM-1 occurs; pix_ready SHALL be low while full.
REQ-019 SHALL use states LOAD, STREAM, WAIT: LOAD->STREAM when a full buffer exists; STREAM->WAIT after the last read issues; WAIT->LOAD (or STREAM if a full buffer exists) on net_done.
REQ-020 SHALL, in STREAM, issue one buffer read per cycle, rd_cnt 0..PIXEL_NUM-1, with no gaps.
REQ-021 SHALL present each sample one cycle after its read, zero-extended: my_input = pix << PIX_SHIFT; input_valid SHALL be high for exactly PIXEL_NUM consecutive cycles per image.
REQ-022 SHALL hold my_input at 0 whenever input_valid is low.
REQ-023 SHALL release the streamed buffer (clear full) when its last sample is output, and increment img_cnt in the same cycle.
REQ-024 SHALL assert busy in STREAM and WAIT only.
REQ-025 SHALL ignore net_done outside WAIT.
REQ-026 SHALL truncate pix_in<<PIX_SHIFT to DATA_WIDTH bits if the shift exceeds the width.

Reset
REQ-027 SHALL on rst set state LOAD, wr_cnt=0, rd_cnt=0, all buffers empty, pix_ready=1, input_valid=0, my_input=0, busy=0, img_cnt=0.
REQ-028 SHALL abort any stream mid-image on rst with no further input_valid; buffer contents need not be cleared.

Configuration
REQ-029 SHALL support macro PINGPONG_BUF_EN.
REQ-030 With PINGPONG_BUF_EN defined, SHALL instantiate two buffers: loading targets the non-streaming buffer, so pix_ready stays high during STREAM/WAIT until that buffer is full; buffers alternate.
REQ-031 Without PINGPONG_BUF_EN, SHALL use one buffer, with pix_ready low from buffer full until WAIT exits on net_done.

Verification
REQ-032 Reset, then 784 pixels of value n mod 256 with sof on the first -> input_valid high for 784 consecutive cycles, my_input = (n mod 256)<<4, img_cnt=1.
REQ-033 Send 300 pixels, then sof and a full 784 -> exactly one 784-sample stream carrying the second image only.
REQ-034 Full image with net_done withheld for 1000 cycles -> busy=1 throughout, no second stream; net_done -> busy=0 or the next stream begins.
REQ-035 PINGPONG_BUF_EN: two images back-to-back -> second image accepted during the first stream, second stream starts the cycle after net_done; without the macro, pix_ready=0 until net_done.
REQ-036 rst asserted at sample 400 -> input_valid=0 the next cycle, img_cnt=0, pix_ready=1.
REQ-037 net_done pulsed during LOAD -> no state change, no img_cnt change.

Source files
------------

// File: rtl/mnist_input_streamer.sv
// Buffers raw MNIST pixels and streams each complete image to the network as fixed-point samples.
// Build option: define PINGPONG_BUF_EN for two alternating buffers (load the next image while streaming).
module mnist_input_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int PIXEL_NUM  = 784,
    parameter int PIX_WIDTH  = 8,
    parameter int PIX_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_WIDTH-1:0]  pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic                  pix_ready,
    input  logic                  net_done,
    output logic [DATA_WIDTH-1:0] my_input,
    output logic                  input_valid,
    output logic                  busy,
    output logic [15:0]           img_cnt
);

    localparam int CNT_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(PIXEL_NUM - 1);
    localparam int EXT_W = (PIX_WIDTH + PIX_SHIFT > DATA_WIDTH) ? (PIX_WIDTH + PIX_SHIFT) : DATA_WIDTH;
`ifdef PINGPONG_BUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        WAIT
    } state_t;

    // Raw pixel placed into the sample word; bits shifted past DATA_WIDTH are dropped.
    function automatic logic [DATA_WIDTH-1:0] scale_pix(input logic [PIX_WIDTH-1:0] p);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(p) << PIX_SHIFT;
        return ext[DATA_WIDTH-1:0];
    endfunction

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        wr_cnt;
    logic [CNT_W-1:0]        wr_addr;
    logic [CNT_W-1:0]        rd_cnt;
    logic [NBUF-1:0]         full;
    logic                    wr_sel;
    logic                    rd_sel;
    logic                    accept;
    logic                    wr_last;
    logic                    rd_issue;
    logic                    rd_last;
    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   smp_p1;
    logic [PIX_WIDTH-1:0]    mem [NBUF][PIXEL_NUM];

    assign accept  = pix_valid && pix_ready;
    assign wr_addr = pix_sof ? '0 : wr_cnt;
    assign wr_last = accept && (wr_addr == LAST_ADDR);
    assign rd_last = rd_issue && (rd_cnt == LAST_ADDR);

`ifdef PINGPONG_BUF_EN
    // Loading always targets wr_sel; it only stalls when that buffer still holds an unstreamed image.
    assign pix_ready = ~full[wr_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (wr_last) wr_sel <= ~wr_sel;
            if (rd_last) rd_sel <= ~rd_sel;
        end
    end
`else
    // Single buffer: no loading from the moment it fills until the network reports back.
    assign pix_ready = (state == LOAD) && ~full[0];
    assign wr_sel    = 1'b0;
    assign rd_sel    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:    if (full[rd_sel]) next_state = STREAM;
            STREAM:  if (rd_cnt == LAST_ADDR) next_state = WAIT;
            WAIT:    if (net_done) next_state = full[rd_sel] ? STREAM : LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        rd_issue = 1'b0;
        unique case (state)
            LOAD:    ;
            STREAM: begin
                busy     = 1'b1;
                rd_issue = 1'b1;
            end
            WAIT:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= '0;
            img_cnt <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (accept) wr_cnt <= wr_last ? '0 : wr_addr + CNT_W'(1);
            if (rd_issue) rd_cnt <= rd_last ? '0 : rd_cnt + CNT_W'(1);
            // Release lands on the edge that exposes the final sample.
            if (rd_last) begin
                full[rd_sel] <= 1'b0;
                img_cnt      <= img_cnt + 16'd1;
            end
            if (wr_last) full[wr_sel] <= 1'b1;
            vld_p1 <= rd_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_sel][wr_addr] <= pix_in;
    end

    // ---- stage p1: buffer read registered and scaled ----
    always_ff @(posedge clk) begin
        if (rd_issue) smp_p1 <= scale_pix(mem[rd_sel][rd_cnt]);
    end

    assign input_valid = vld_p1;
    assign my_input    = vld_p1 ? smp_p1 : '0;

endmodule

// File: tb/tb_mnist_input_streamer.sv
// Randomised bench for mnist_input_streamer: an image-level queue model predicts every streamed sample.
module tb_mnist_input_streamer;

    localparam int DATA_WIDTH = 16;
    localparam int PIXEL_NUM  = 784;
    localparam int PIX_WIDTH  = 8;
    localparam int PIX_SHIFT  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PIX_WIDTH-1:0]  pix_in;
    logic                  pix_valid;
    logic                  pix_sof;
    logic                  pix_ready;
    logic                  net_done;
    logic [DATA_WIDTH-1:0] my_input;
    logic                  input_valid;
    logic                  busy;
    logic [15:0]           img_cnt;

    mnist_input_streamer #(
        .DATA_WIDTH(DATA_WIDTH),
        .PIXEL_NUM (PIXEL_NUM),
        .PIX_WIDTH (PIX_WIDTH),
        .PIX_SHIFT (PIX_SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .net_done   (net_done),
        .my_input   (my_input),
        .input_valid(input_valid),
        .busy       (busy),
        .img_cnt    (img_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        bit          last;
    } smp_t;

    smp_t                 exp_q[$];
    logic [PIX_WIDTH-1:0] partial[$];
    smp_t                 mon_e;
    int                   exp_img;
    int                   run_len;
    int                   tests_run;
    int                   tests_failed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_sample(input logic [PIX_WIDTH-1:0] p);
        int v;
        v = int'(p) * (2 ** PIX_SHIFT);
        return 16'(v % 65536);
    endfunction

    // Model: whole images are collected from handshakes and queued as flat sample sequences.
    always @(negedge clk) begin
        if (input_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(input_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample", 32'(my_input), 32'(mon_e.val));
                run_len++;
                if (mon_e.last) begin
                    exp_img = (exp_img + 1) % 65536;
                    chk("img_cnt_at_last", 32'(img_cnt), 32'(exp_img));
                end
            end
        end else begin
            chk("idle_my_input_zero", 32'(my_input), 32'd0);
            if (run_len != 0) begin
                chk("stream_len", 32'(run_len), 32'(PIXEL_NUM));
                run_len = 0;
            end
        end
        if (rst) begin
            exp_q.delete();
            partial.delete();
            exp_img = 0;
            run_len = 0;
        end else if (pix_valid && pix_ready) begin
            if (pix_sof) partial.delete();
            partial.push_back(pix_in);
            if (partial.size() == PIXEL_NUM) begin
                for (int i = 0; i < PIXEL_NUM; i++)
                    exp_q.push_back('{val: ref_sample(partial[i]), last: (i == PIXEL_NUM - 1)});
                partial.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [PIX_WIDTH-1:0] p, input logic sof);
        int guard;
        guard     = 0;
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && guard < 4000) begin
            guard++;
            @(negedge clk);
        end
        if (!pix_ready) chk("ready_timeout", 32'(pix_ready), 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_image(input bit rand_pix, input bit gaps);
        logic [PIX_WIDTH-1:0] px;
        for (int i = 0; i < PIXEL_NUM; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            px = rand_pix ? PIX_WIDTH'($urandom_range(0, 255)) : PIX_WIDTH'(i % 256);
            send_pix(px, i == 0);
        end
    endtask

    task automatic wait_img(input int target);
        int guard;
        guard = 0;
        while (exp_img != target && guard < 5000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("stream_done", 32'(exp_img), 32'(target));
    endtask

    task automatic pulse_done();
        net_done = 1'b1;
        tick();
        net_done = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_busy;
        int bad_ready;
        int guard;
        int tgt;
        tests_run    = 0;
        tests_failed = 0;
        exp_img      = 0;
        run_len      = 0;
        rst          = 1'b1;
        pix_valid    = 1'b0;
        pix_sof      = 1'b0;
        pix_in       = '0;
        net_done     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        @(negedge clk); #1;
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_input_valid", 32'(input_valid), 32'd0);
        chk("rst_my_input", 32'(my_input), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_img_cnt", 32'(img_cnt), 32'd0);
        tick();

        // net_done outside WAIT must be ignored, also mid-load
        for (int i = 0; i < 50; i++) send_pix(PIX_WIDTH'($urandom_range(0, 255)), i == 0);
        pulse_done();
        @(negedge clk); #1;
        chk("ld_done_busy", 32'(busy), 32'd0);
        chk("ld_done_img_cnt", 32'(img_cnt), 32'd0);
        chk("ld_done_ready", 32'(pix_ready), 32'd1);
        tick();

        // ramp image n mod 256, back-to-back pixels
        send_image(1'b0, 1'b0);
        wait_img(1);
        chk("ramp_img_cnt", 32'(img_cnt), 32'd1);
        chk("ramp_busy_wait", 32'(busy), 32'd1);
        tick();
        pulse_done();
        @(negedge clk); #1;
        chk("ramp_busy_after_done", 32'(busy), 32'd0);
        chk("ramp_ready_after_done", 32'(pix_ready), 32'd1);
        tick();

        // partial image discarded by a new sof
        for (int i = 0; i < 300; i++) send_pix(PIX_WIDTH'($urandom_range(0, 255)), i == 0);
        send_image(1'b1, 1'b1);
        wait_img(2);
        repeat (10) tick();
        chk("partial_img_cnt", 32'(img_cnt), 32'd2);
        chk("partial_model_empty", 32'(exp_q.size()), 32'd0);
        pulse_done();

        // net_done withheld for 1000 cycles
        send_image(1'b1, 1'b1);
        wait_img(3);
        bad_busy  = 0;
        bad_ready = 0;
`ifndef PINGPONG_BUF_EN
        pix_in    = PIX_WIDTH'($urandom_range(0, 255));
        pix_valid = 1'b1;
`endif
        repeat (1000) begin
            @(negedge clk); #1;
            if (busy !== 1'b1) bad_busy++;
`ifdef PINGPONG_BUF_EN
            if (pix_ready !== 1'b1) bad_ready++;
`else
            if (pix_ready !== 1'b0) bad_ready++;
`endif
        end
        pix_valid = 1'b0;
        chk("hold_busy_drops", 32'(bad_busy), 32'd0);
        chk("hold_ready_wrong", 32'(bad_ready), 32'd0);
        chk("hold_img_cnt", 32'(img_cnt), 32'd3);
        tick();
        pulse_done();
        @(negedge clk); #1;
        chk("hold_busy_after_done", 32'(busy), 32'd0);
        tick();

        // two images back-to-back
        tgt = exp_img + 1;
`ifdef PINGPONG_BUF_EN
        send_image(1'b1, 1'b0);
        send_image(1'b1, 1'b0);
        chk("pp_loaded_during_stream", 32'(input_valid), 32'd1);
        wait_img(tgt);
        tick();
        net_done = 1'b1;
        @(negedge clk); #1;
        chk("pp_idle_before_done", 32'(input_valid), 32'd0);
        @(posedge clk); #1;
        net_done = 1'b0;
        @(negedge clk); #1;
        chk("pp_busy_after_done", 32'(busy), 32'd1);
        chk("pp_latency_cycle0", 32'(input_valid), 32'd0);
        @(negedge clk); #1;
        chk("pp_latency_cycle1", 32'(input_valid), 32'd1);
        wait_img(tgt + 1);
        tick();
        pulse_done();
`else
        send_image(1'b1, 1'b0);
        pix_in    = PIX_WIDTH'($urandom_range(0, 255));
        pix_sof   = 1'b1;
        pix_valid = 1'b1;
        bad_ready = 0;
        guard     = 0;
        while (exp_img != tgt && guard < 5000) begin
            @(negedge clk); #1;
            if (pix_ready) bad_ready++;
            guard++;
        end
        chk("np_stream_done", 32'(exp_img), 32'(tgt));
        repeat (20) begin
            @(negedge clk); #1;
            if (pix_ready) bad_ready++;
        end
        chk("np_ready_low_until_done", 32'(bad_ready), 32'd0);
        tick();
        net_done = 1'b1;
        tick();
        net_done  = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(negedge clk); #1;
        chk("np_ready_after_done", 32'(pix_ready), 32'd1);
        tick();
        send_image(1'b1, 1'b1);
        wait_img(tgt + 1);
        tick();
        pulse_done();
`endif

        // reset in the middle of a stream
        send_image(1'b1, 1'b1);
        guard = 0;
        while (run_len < 400 && guard < 5000) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("abort_point_reached", 32'(run_len >= 400), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_input_valid", 32'(input_valid), 32'd0);
        chk("abort_img_cnt", 32'(img_cnt), 32'd0);
        chk("abort_pix_ready", 32'(pix_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("abort_no_more_valid", 32'(input_valid), 32'd0);

        // recovery after abort
        send_image(1'b1, 1'b1);
        wait_img(1);
        chk("recover_img_cnt", 32'(img_cnt), 32'd1);
        tick();
        pulse_done();
        @(negedge clk); #1;
        chk("recover_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
